// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit sitting in front of a word-wide, 1-cycle-read data RAM.
// Handles RV32I byte/half/word accesses, sub-word stores by read-modify-write.
module lsu_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter bit          DEBUG       = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_WAIT, S_RMW_MERGE, S_RESP} state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  state_t      state;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [15:0] wdata_q;

  logic illegal, misaligned, out_of_range, req_err, accept, is_sw;
  logic [31:0] load_data, merged;

  always_comb begin
    illegal      = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                || (req_we && req_funct3[2]);
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = req_addr >= ADDR_LIMIT;
    req_err      = illegal || misaligned || out_of_range;
    is_sw        = req_we && (req_funct3[1:0] == 2'b10);
  end

  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [15:0] wd,
                                             input logic is_half, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    if (is_half) r[16*off[1] +: 16] = wd;
    else         r[8*off +: 8]      = wd[7:0];
    return r;
  endfunction

  // Lane select and extension of the registered RAM word for the pending load.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = mem_rdata[8*off_q +: 8];
    h = mem_rdata[16*off_q[1] +: 16];
    case (f3_q)
      3'b000:  load_data = {{24{b[7]}}, b};
      3'b001:  load_data = {{16{h[15]}}, h};
      3'b100:  load_data = {24'd0, b};
      3'b101:  load_data = {16'd0, h};
      default: load_data = mem_rdata;
    endcase
  end

  assign merged = merge_lane(mem_rdata, wdata_q, f3_q[0], off_q);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = {addr_q, 2'b00};
    mem_wdata = merged;
    case (state)
      S_IDLE: begin
        mem_addr  = {req_addr[31:2], 2'b00};
        mem_wdata = req_wdata;
        if (accept && !req_err) begin
          mem_wen = is_sw;
          mem_ren = !is_sw;
        end
      end
      S_RMW_MERGE: mem_wen = !rst;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (req_err || is_sw) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= req_err;
            end else if (req_we) begin
              state <= S_RMW_MERGE;
            end else begin
              state <= S_LOAD_WAIT;
            end
          end
        end
        S_LOAD_WAIT: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
        end
        S_RMW_MERGE: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: request latches are pure datapath, only read in states entered after a fresh accept,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr[31:2];
      off_q   <= req_addr[1:0];
      f3_q    <= req_funct3;
      wdata_q <= req_wdata[15:0];
    end
  end

  // Optional runtime self-checks enabled for debug builds.
  if (DEBUG) begin : g_debug
    a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
      (mem_wen || mem_ren) |-> (mem_addr[1:0] == 2'b00));
    a_err_no_data: assert property (@(posedge clk)
      (resp_valid && resp_err) |-> (resp_rdata == '0));
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: behavioural RAM, byte-array reference model,
// directed cases plus randomized traffic.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rdata;

  lsu_mem_ctrl #(.DEPTH_WORDS(1024), .DEBUG(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural simple_ram: whole-word write, registered read.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr[11:2]] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_addr[11:2]];
  end

  // Reference memory, byte granular.
  logic [7:0] model_mem [4096];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    if (addr % size_of(f3) != 0) return 1'b1;
    return addr >= 32'd4096;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] v = 0;
    for (int i = 0; i < 4; i++) v = v | (32'(model_mem[int'(a[11:0]) + i]) << (8 * i));
    return v;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v = 0;
    for (int i = 0; i < size_of(f3); i++)
      v = v | (32'(model_mem[int'(addr[11:0]) + i]) << (8 * i));
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic sample_mem(input string tag, input logic [31:0] aligned, input logic [31:0] exp_word,
                            inout int nwen, inout int nren);
    nwen += int'(mem_wen);
    nren += int'(mem_ren);
    if (mem_wen || mem_ren) check({tag, "_addr"}, mem_addr, aligned);
    if (mem_wen) check({tag, "_wdata"}, mem_wdata, exp_word);
  endtask

  // One complete request: expectations come from the reference model.
  task automatic do_req(input string tag, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bit          exp_err, got;
    int          exp_lat, exp_wen, exp_ren, nwen, nren, lat, w;
    logic [31:0] exp_rdata, exp_word, aligned, rd, er;
    exp_err   = model_err(we, f3, addr);
    aligned   = {addr[31:2], 2'b00};
    exp_lat   = (exp_err || (we && f3 == 3'b010)) ? 1 : 2;
    exp_wen   = (!exp_err && we) ? 1 : 0;
    exp_ren   = (!exp_err && !(we && f3 == 3'b010)) ? 1 : 0;
    exp_rdata = (!exp_err && !we) ? model_load(f3, addr) : 32'd0;
    exp_word  = 0;
    if (!exp_err && we) begin
      exp_word = model_word(aligned);
      for (int i = 0; i < size_of(f3); i++)
        exp_word[8 * (int'(addr[1:0]) + i) +: 8] = wdata[8 * i +: 8];
    end
    nwen = 0; nren = 0; w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    while (!req_ready && w < 8) begin
      @(negedge clk); #1; w++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    sample_mem(tag, aligned, exp_word, nwen, nren);
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0; lat = 0; rd = 0; er = 0;
    for (int k = 1; k <= 6 && !got; k++) begin
      @(negedge clk);
      sample_mem(tag, aligned, exp_word, nwen, nren);
      if (resp_valid) begin
        got = 1; lat = k; er = 32'(resp_err); rd = resp_rdata;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_err"}, er, 32'(exp_err));
    check({tag, "_rdata"}, rd, exp_rdata);
    check({tag, "_wen_cnt"}, nwen, exp_wen);
    check({tag, "_ren_cnt"}, nren, exp_ren);
    last_rdata = rd;
    if (!exp_err && we)
      for (int i = 0; i < size_of(f3); i++) model_mem[int'(addr[11:0]) + i] = wdata[8 * i +: 8];
  endtask

  // Hold one request on req_valid for ten cycles and measure accept spacing.
  task automatic back_to_back(input string tag, input bit we, input logic [2:0] f3,
                              input logic [31:0] addr, input int spacing, input int exp_n);
    int last, n;
    last = -1; n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = 32'hCAFE_F00D;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready) begin
        if (last >= 0) check({tag, "_spacing"}, c - last, spacing);
        last = c; n++;
      end
    end
    req_valid = 1'b0;
    check({tag, "_accepts"}, n, exp_n);
    if (we) for (int i = 0; i < 4; i++) model_mem[int'(addr[11:0]) + i] = req_wdata[8 * i +: 8];
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 0; req_wdata = 0; last_rdata = 0;
    repeat (3) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wen", 32'(mem_wen), 32'd0);
    check("rst_ren", 32'(mem_ren), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    req_valid = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 64; i++) do_req("prefill", 1'b1, 3'b010, 32'(i * 4), $urandom);

    do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0);
    check("lw10_value", last_rdata, 32'hDEAD_BEEF);

    do_req("sw20", 1'b1, 3'b010, 32'h20, 32'h1122_3344);
    do_req("sb22", 1'b1, 3'b000, 32'h22, 32'h0000_00AA);
    @(negedge clk);
    check("ram20", ram[8], 32'h11AA_3344);
    do_req("lb22", 1'b0, 3'b000, 32'h22, 32'h0);
    check("lb22_value", last_rdata, 32'hFFFF_FFAA);
    do_req("lbu22", 1'b0, 3'b100, 32'h22, 32'h0);
    check("lbu22_value", last_rdata, 32'h0000_00AA);

    do_req("sw30", 1'b1, 3'b010, 32'h30, 32'h0);
    do_req("sh32", 1'b1, 3'b001, 32'h32, 32'h0000_8001);
    @(negedge clk);
    check("ram30", ram[12], 32'h8001_0000);
    do_req("lh32", 1'b0, 3'b001, 32'h32, 32'h0);
    check("lh32_value", last_rdata, 32'hFFFF_8001);
    do_req("lhu32", 1'b0, 3'b101, 32'h32, 32'h0);
    check("lhu32_value", last_rdata, 32'h0000_8001);

    do_req("err_lw41", 1'b0, 3'b010, 32'h41, 32'h0);
    do_req("err_sh43", 1'b1, 3'b001, 32'h43, 32'h1234);
    do_req("err_f3_011", 1'b0, 3'b011, 32'h40, 32'h0);
    do_req("err_sb1000", 1'b1, 3'b000, 32'h1000, 32'h55);
    do_req("err_sbu", 1'b1, 3'b100, 32'h44, 32'h55);
    do_req("edge_lw_ffc", 1'b0, 3'b010, 32'hFFC, 32'h0);

    // Reset lands in the RMW_MERGE cycle of SB 0x50.
    do_req("sw50", 1'b1, 3'b010, 32'h50, 32'h0102_0304);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h50; req_wdata = 32'h77;
    #1;
    check("rmw_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; #1;
    check("rmw_rst_wen", 32'(mem_wen), 32'd0);
    @(negedge clk);
    rst = 1'b0; #1;
    check("rmw_rst_resp", 32'(resp_valid), 32'd0);
    check("rmw_rst_ready_after", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rmw_rst_quiet", {30'd0, resp_valid, mem_wen}, 32'd0);
    end
    check("ram50", ram[20], 32'h0102_0304);
    do_req("lw50", 1'b0, 3'b010, 32'h50, 32'h0);

    back_to_back("b2b_sw", 1'b1, 3'b010, 32'h60, 2, 5);
    back_to_back("b2b_lw", 1'b0, 3'b010, 32'h60, 3, 4);
    do_req("lw60", 1'b0, 3'b010, 32'h60, 32'h0);

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 15);
      if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 255));
      else if (r == 1) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else             a = 32'($urandom_range(0, 255));
      do_req("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("final_ram", ram[i], model_word(32'(i * 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
